// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the hazard controller and the EX operand-mux users.
package hazard_ctrl_unit_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // x0 is hardwired; it never creates a dependency
   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// One-entry scoreboard tracking the destination of the in-flight MDU op.
module hazard_scoreboard
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          is_mdu_ex,
   input  logic          rd_wren_ex,
   input  logic [AW-1:0] rd_addr_ex,
   input  logic          mem_wait,
   input  logic          mdu_done,
   output logic          busy,
   output logic [AW-1:0] rd,
   output logic          pending_c
);

   logic issue;

   assign issue = is_mdu_ex & rd_wren_ex & (rd_addr_ex != AW'(REG_ZERO)) & ~mem_wait;

   // A retiring op does not block consumers in the cycle its result is written
   assign pending_c = busy & ~mdu_done;

   // Issue beats retire so back-to-back MDU ops keep the entry occupied
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         rd   <= '0;
      end else if (issue) begin
         busy <= 1'b1;
         rd   <= rd_addr_ex;
      end else if (mdu_done) begin
         busy <= 1'b0;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Forwarding, stall, flush and stall-cycle accounting for the 5-stage core.
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned AW        = 5,
   parameter bit          ID_BYPASS = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rs1_addr_ID,
   input  logic [AW-1:0]    rs2_addr_ID,
   input  logic             rs1_used_ID,
   input  logic             rs2_used_ID,
   input  logic [AW-1:0]    rd_addr_ID,
   input  logic             rd_wren_ID,
   input  logic             is_mdu_ID,
   input  logic [AW-1:0]    rs1_addr_EX,
   input  logic [AW-1:0]    rs2_addr_EX,
   input  logic [AW-1:0]    rd_addr_EX,
   input  logic             rd_wren_EX,
   input  logic             is_load_EX,
   input  logic             is_mdu_EX,
   input  logic             pc_sel_EX,
   input  logic [AW-1:0]    rd_addr_MEM,
   input  logic             rd_wren_MEM,
   input  logic             is_load_MEM,
   input  logic             dmem_ready,
   input  logic [AW-1:0]    rd_addr_WB,
   input  logic             rd_wren_WB,
   input  logic             mdu_done,
   input  logic             clr_cnt,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             byp_rs1_ID,
   output logic             byp_rs2_ID,
   output logic             stall_pc,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             stall_EX,
   output logic             stall_MEM,
   output logic             flush_IF,
   output logic             flush_ID,
   output logic             bubble_WB,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic          mem_wait;
   logic          hz;
   logic          sb_pending;
   logic [AW-1:0] sb_rd;
   fwd_sel_e      fwd_a_sel;
   fwd_sel_e      fwd_b_sel;

   function automatic logic reg_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return (a != AW'(REG_ZERO)) && (a == b);
   endfunction

   // MEM is preferred over WB; a load in MEM has no data yet to forward
   function automatic fwd_sel_e fwd_pick(input logic [AW-1:0] rs);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (rd_wren_MEM && !is_load_MEM && reg_hit(rd_addr_MEM, rs)) begin
         sel = FWD_MEM;
      end else if (rd_wren_WB && reg_hit(rd_addr_WB, rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   // Only source fields the ID instruction actually reads can create a hazard
   function automatic logic id_reads(input logic [AW-1:0] r);
      return (rs1_used_ID && reg_hit(r, rs1_addr_ID)) ||
             (rs2_used_ID && reg_hit(r, rs2_addr_ID));
   endfunction

   hazard_scoreboard #(.AW(AW)) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .is_mdu_ex  (is_mdu_EX),
      .rd_wren_ex (rd_wren_EX),
      .rd_addr_ex (rd_addr_EX),
      .mem_wait   (mem_wait),
      .mdu_done   (mdu_done),
      .busy       (mdu_busy),
      .rd         (sb_rd),
      .pending_c  (sb_pending)
   );

   assign mem_wait = is_load_MEM & ~dmem_ready;

   always_comb begin
      fwd_a_sel = fwd_pick(rs1_addr_EX);
      fwd_b_sel = fwd_pick(rs2_addr_EX);
   end

   assign fwd_a = 2'(fwd_a_sel);
   assign fwd_b = 2'(fwd_b_sel);

   assign byp_rs1_ID = ID_BYPASS & rd_wren_WB & reg_hit(rd_addr_WB, rs1_addr_ID);
   assign byp_rs2_ID = ID_BYPASS & rd_wren_WB & reg_hit(rd_addr_WB, rs2_addr_ID);

   // Interlock sources; a memory wait freezes everything and masks them
   always_comb begin
      hz = 1'b0;
      if (rd_wren_EX && (is_load_EX || is_mdu_EX) && id_reads(rd_addr_EX)) begin
         hz = 1'b1;
      end
      if (sb_pending && (id_reads(sb_rd) || (rd_wren_ID && reg_hit(rd_addr_ID, sb_rd)))) begin
         hz = 1'b1;
      end
      if (is_mdu_ID && (sb_pending || is_mdu_EX)) begin
         hz = 1'b1;
      end
      if (mem_wait) begin
         hz = 1'b0;
      end
   end

   // A taken branch discards the ID instruction, so it overrides the front-end hold
   assign stall_pc  = mem_wait | (hz & ~pc_sel_EX);
   assign stall_IF  = stall_pc;
   assign stall_ID  = mem_wait;
   assign stall_EX  = mem_wait;
   assign stall_MEM = mem_wait;
   assign bubble_WB = mem_wait;
   assign flush_IF  = pc_sel_EX & ~mem_wait;
   assign flush_ID  = (hz | pc_sel_EX) & ~mem_wait;

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         stall_cycles <= '0;
      end else if (stall_pc && (stall_cycles != CNT_MAX)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed and random checks of hazard_ctrl_unit against a behavioural model.
module tb_hazard_ctrl_unit;

   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] rs1_addr_ID, rs2_addr_ID, rd_addr_ID;
   logic          rs1_used_ID, rs2_used_ID, rd_wren_ID, is_mdu_ID;
   logic [AW-1:0] rs1_addr_EX, rs2_addr_EX, rd_addr_EX;
   logic          rd_wren_EX, is_load_EX, is_mdu_EX, pc_sel_EX;
   logic [AW-1:0] rd_addr_MEM, rd_addr_WB;
   logic          rd_wren_MEM, is_load_MEM, dmem_ready, rd_wren_WB, mdu_done, clr_cnt;

   logic [1:0] fwd_a, fwd_b;
   logic       byp_rs1_ID, byp_rs2_ID, stall_pc, stall_IF, stall_ID, stall_EX, stall_MEM;
   logic       flush_IF, flush_ID, bubble_WB, mdu_busy;
   logic [3:0] stall_cycles;

   logic [1:0] d2_fwd_a, d2_fwd_b;
   logic       d2_byp_rs1_ID, d2_byp_rs2_ID, d2_stall_pc, d2_stall_IF, d2_stall_ID, d2_stall_EX;
   logic       d2_stall_MEM, d2_flush_IF, d2_flush_ID, d2_bubble_WB, d2_mdu_busy;
   logic [1:0] d2_stall_cycles;

   hazard_ctrl_unit #(.AW(AW), .ID_BYPASS(1'b1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
      .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .rd_addr_ID(rd_addr_ID), .rd_wren_ID(rd_wren_ID), .is_mdu_ID(is_mdu_ID),
      .rs1_addr_EX(rs1_addr_EX), .rs2_addr_EX(rs2_addr_EX), .rd_addr_EX(rd_addr_EX),
      .rd_wren_EX(rd_wren_EX), .is_load_EX(is_load_EX), .is_mdu_EX(is_mdu_EX),
      .pc_sel_EX(pc_sel_EX), .rd_addr_MEM(rd_addr_MEM), .rd_wren_MEM(rd_wren_MEM),
      .is_load_MEM(is_load_MEM), .dmem_ready(dmem_ready), .rd_addr_WB(rd_addr_WB),
      .rd_wren_WB(rd_wren_WB), .mdu_done(mdu_done), .clr_cnt(clr_cnt),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .byp_rs1_ID(byp_rs1_ID), .byp_rs2_ID(byp_rs2_ID),
      .stall_pc(stall_pc), .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
      .stall_MEM(stall_MEM), .flush_IF(flush_IF), .flush_ID(flush_ID),
      .bubble_WB(bubble_WB), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
   );

   hazard_ctrl_unit #(.AW(AW), .ID_BYPASS(1'b0), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
      .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .rd_addr_ID(rd_addr_ID), .rd_wren_ID(rd_wren_ID), .is_mdu_ID(is_mdu_ID),
      .rs1_addr_EX(rs1_addr_EX), .rs2_addr_EX(rs2_addr_EX), .rd_addr_EX(rd_addr_EX),
      .rd_wren_EX(rd_wren_EX), .is_load_EX(is_load_EX), .is_mdu_EX(is_mdu_EX),
      .pc_sel_EX(pc_sel_EX), .rd_addr_MEM(rd_addr_MEM), .rd_wren_MEM(rd_wren_MEM),
      .is_load_MEM(is_load_MEM), .dmem_ready(dmem_ready), .rd_addr_WB(rd_addr_WB),
      .rd_wren_WB(rd_wren_WB), .mdu_done(mdu_done), .clr_cnt(clr_cnt),
      .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .byp_rs1_ID(d2_byp_rs1_ID), .byp_rs2_ID(d2_byp_rs2_ID),
      .stall_pc(d2_stall_pc), .stall_IF(d2_stall_IF), .stall_ID(d2_stall_ID),
      .stall_EX(d2_stall_EX), .stall_MEM(d2_stall_MEM), .flush_IF(d2_flush_IF),
      .flush_ID(d2_flush_ID), .bubble_WB(d2_bubble_WB), .mdu_busy(d2_mdu_busy),
      .stall_cycles(d2_stall_cycles)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: pending MDU destination and the two stall counters
   int m_busy, m_rd, m_cnt4, m_cnt2;
   int e_fwd_a, e_fwd_b, e_byp1, e_byp2, e_stall_pc, e_back, e_flush_if, e_flush_id;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit same(input int a, input int b);
      return (a != 0) && (a == b);
   endfunction

   function automatic int fwd_of(input int rs);
      if (rd_wren_MEM && !is_load_MEM && same(int'(rd_addr_MEM), rs)) return 2;
      if (rd_wren_WB && same(int'(rd_addr_WB), rs)) return 1;
      return 0;
   endfunction

   function automatic bit reads(input int r);
      return (rs1_used_ID && same(r, int'(rs1_addr_ID))) ||
             (rs2_used_ID && same(r, int'(rs2_addr_ID)));
   endfunction

   task automatic model_eval();
      bit mw, pend, hz;
      mw   = is_load_MEM && !dmem_ready;
      pend = (m_busy != 0) && !mdu_done;
      hz   = 1'b0;
      if ((is_load_EX || is_mdu_EX) && rd_wren_EX && reads(int'(rd_addr_EX))) hz = 1'b1;
      if (pend && (reads(m_rd) || (rd_wren_ID && same(int'(rd_addr_ID), m_rd)))) hz = 1'b1;
      if (is_mdu_ID && (pend || is_mdu_EX)) hz = 1'b1;
      if (mw) hz = 1'b0;
      e_fwd_a    = fwd_of(int'(rs1_addr_EX));
      e_fwd_b    = fwd_of(int'(rs2_addr_EX));
      e_byp1     = int'(rd_wren_WB && same(int'(rd_addr_WB), int'(rs1_addr_ID)));
      e_byp2     = int'(rd_wren_WB && same(int'(rd_addr_WB), int'(rs2_addr_ID)));
      e_stall_pc = int'(mw || (hz && !pc_sel_EX));
      e_back     = int'(mw);
      e_flush_if = int'(pc_sel_EX && !mw);
      e_flush_id = int'((hz || pc_sel_EX) && !mw);
   endtask

   task automatic check_model();
      logic [12:0] obs2, exp2;
      chk("fwd_a", 32'(fwd_a), 32'(e_fwd_a));
      chk("fwd_b", 32'(fwd_b), 32'(e_fwd_b));
      chk("byp_rs1", 32'(byp_rs1_ID), 32'(e_byp1));
      chk("byp_rs2", 32'(byp_rs2_ID), 32'(e_byp2));
      chk("stall_pc", 32'(stall_pc), 32'(e_stall_pc));
      chk("stall_IF", 32'(stall_IF), 32'(e_stall_pc));
      chk("stall_ID", 32'(stall_ID), 32'(e_back));
      chk("stall_EX", 32'(stall_EX), 32'(e_back));
      chk("stall_MEM", 32'(stall_MEM), 32'(e_back));
      chk("bubble_WB", 32'(bubble_WB), 32'(e_back));
      chk("flush_IF", 32'(flush_IF), 32'(e_flush_if));
      chk("flush_ID", 32'(flush_ID), 32'(e_flush_id));
      chk("mdu_busy", 32'(mdu_busy), 32'(m_busy));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt4));
      chk("d2_byp", 32'({d2_byp_rs1_ID, d2_byp_rs2_ID}), 32'd0);
      chk("d2_stall_cycles", 32'(d2_stall_cycles), 32'(m_cnt2));
      obs2 = {d2_fwd_a, d2_fwd_b, d2_stall_pc, d2_stall_IF, d2_stall_ID, d2_stall_EX,
              d2_stall_MEM, d2_flush_IF, d2_flush_ID, d2_bubble_WB, d2_mdu_busy};
      exp2 = {2'(e_fwd_a), 2'(e_fwd_b), 1'(e_stall_pc), 1'(e_stall_pc), 1'(e_back),
              1'(e_back), 1'(e_back), 1'(e_flush_if), 1'(e_flush_id), 1'(e_back), 1'(m_busy)};
      chk("d2_ctl", 32'(obs2), 32'(exp2));
   endtask

   task automatic model_update();
      if (rst) begin
         m_busy = 0; m_rd = 0; m_cnt4 = 0; m_cnt2 = 0;
      end else begin
         if (is_mdu_EX && rd_wren_EX && rd_addr_EX != 0 && !(is_load_MEM && !dmem_ready)) begin
            m_busy = 1; m_rd = int'(rd_addr_EX);
         end else if (mdu_done) begin
            m_busy = 0;
         end
         if (clr_cnt) begin
            m_cnt4 = 0; m_cnt2 = 0;
         end else if (e_stall_pc != 0) begin
            if (m_cnt4 < 15) m_cnt4++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
   endtask

   task automatic eval();
      @(negedge clk);
      model_eval();
      check_model();
   endtask

   task automatic adv();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0;
      rs1_addr_ID = '0; rs2_addr_ID = '0; rd_addr_ID = '0;
      rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; rd_wren_ID = 1'b0; is_mdu_ID = 1'b0;
      rs1_addr_EX = '0; rs2_addr_EX = '0; rd_addr_EX = '0;
      rd_wren_EX = 1'b0; is_load_EX = 1'b0; is_mdu_EX = 1'b0; pc_sel_EX = 1'b0;
      rd_addr_MEM = '0; rd_wren_MEM = 1'b0; is_load_MEM = 1'b0; dmem_ready = 1'b1;
      rd_addr_WB = '0; rd_wren_WB = 1'b0; mdu_done = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic rand_inputs();
      rst = ($urandom_range(0, 99) == 0);
      rs1_addr_ID = AW'($urandom_range(0, 3)); rs2_addr_ID = AW'($urandom_range(0, 3));
      rd_addr_ID  = AW'($urandom_range(0, 3));
      rs1_used_ID = 1'($urandom_range(0, 1)); rs2_used_ID = 1'($urandom_range(0, 1));
      rd_wren_ID  = 1'($urandom_range(0, 1)); is_mdu_ID = ($urandom_range(0, 3) == 0);
      rs1_addr_EX = AW'($urandom_range(0, 3)); rs2_addr_EX = AW'($urandom_range(0, 3));
      rd_addr_EX  = AW'($urandom_range(0, 3));
      rd_wren_EX  = 1'($urandom_range(0, 1)); is_load_EX = ($urandom_range(0, 3) == 0);
      is_mdu_EX   = ($urandom_range(0, 3) == 0); pc_sel_EX = ($urandom_range(0, 7) == 0);
      rd_addr_MEM = AW'($urandom_range(0, 3)); rd_wren_MEM = 1'($urandom_range(0, 1));
      is_load_MEM = ($urandom_range(0, 3) == 0); dmem_ready = ($urandom_range(0, 3) != 0);
      rd_addr_WB  = AW'($urandom_range(0, 3)); rd_wren_WB = 1'($urandom_range(0, 1));
      mdu_done    = ($urandom_range(0, 3) == 0); clr_cnt = ($urandom_range(0, 31) == 0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_busy = 0; m_rd = 0; m_cnt4 = 0; m_cnt2 = 0;

      // Idle after reset: everything low
      eval();
      chk("rst_stall", 32'(stall_pc), 32'd0);
      chk("rst_cnt", 32'(stall_cycles), 32'd0);
      adv();

      // Forwarding priority and x0
      rd_wren_MEM = 1'b1; rd_addr_MEM = 5'd5; rd_wren_WB = 1'b1; rd_addr_WB = 5'd5;
      rs1_addr_EX = 5'd5;
      eval(); chk("fwd_prio", 32'(fwd_a), 32'd2); adv();
      rs1_addr_EX = 5'd0;
      eval(); chk("fwd_x0", 32'(fwd_a), 32'd0); adv();

      // Load-use: one stall cycle, then the bubble sits in EX
      idle();
      is_load_EX = 1'b1; rd_wren_EX = 1'b1; rd_addr_EX = 5'd7;
      rs2_addr_ID = 5'd7; rs2_used_ID = 1'b1;
      eval(); chk("lu_stall", 32'(stall_pc), 32'd1); chk("lu_flush_id", 32'(flush_ID), 32'd1);
      chk("lu_stall_id", 32'(stall_ID), 32'd0); adv();
      idle(); rs2_addr_ID = 5'd7; rs2_used_ID = 1'b1;
      eval(); chk("lu_release", 32'(stall_pc), 32'd0); adv();
      is_load_EX = 1'b1; rd_wren_EX = 1'b1; rd_addr_EX = 5'd7; rs2_used_ID = 1'b0;
      eval(); chk("lu_unused", 32'(stall_pc), 32'd0); adv();

      // Memory wait holds a taken branch for three cycles
      idle(); is_load_MEM = 1'b1; dmem_ready = 1'b0; pc_sel_EX = 1'b1;
      for (int i = 0; i < 3; i++) begin
         eval();
         chk("mw_stall", 32'(stall_MEM), 32'd1);
         chk("mw_bubble", 32'(bubble_WB), 32'd1);
         chk("mw_flush_if", 32'(flush_IF), 32'd0);
         adv();
      end
      dmem_ready = 1'b1;
      eval(); chk("mw_end_flush_if", 32'(flush_IF), 32'd1);
      chk("mw_end_flush_id", 32'(flush_ID), 32'd1); adv();

      // MDU RAW on x9 until done
      idle(); is_mdu_EX = 1'b1; rd_wren_EX = 1'b1; rd_addr_EX = 5'd9;
      rs1_addr_ID = 5'd9; rs1_used_ID = 1'b1;
      eval(); chk("mdu_ex_raw", 32'(stall_pc), 32'd1); adv();
      idle(); rs1_addr_ID = 5'd9; rs1_used_ID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         eval(); chk("mdu_sb_raw", 32'(stall_pc), 32'd1); chk("mdu_busy_on", 32'(mdu_busy), 32'd1);
         adv();
      end
      mdu_done = 1'b1;
      eval(); chk("mdu_done_release", 32'(stall_pc), 32'd0); adv();
      mdu_done = 1'b0;
      eval(); chk("mdu_busy_off", 32'(mdu_busy), 32'd0); adv();

      // Done and issue in the same cycle: entry now tracks x3
      idle(); is_mdu_EX = 1'b1; rd_wren_EX = 1'b1; rd_addr_EX = 5'd12;
      eval(); adv();
      mdu_done = 1'b1; rd_addr_EX = 5'd3;
      eval(); adv();
      idle(); rs2_addr_ID = 5'd3; rs2_used_ID = 1'b1;
      eval(); chk("sb_reissue_busy", 32'(mdu_busy), 32'd1);
      chk("sb_reissue_rd3", 32'(stall_pc), 32'd1); adv();

      // Reset mid-op drops the entry
      rst = 1'b1;
      eval(); adv();
      rst = 1'b0;
      eval(); chk("rst_drop_busy", 32'(mdu_busy), 32'd0);
      chk("rst_drop_stall", 32'(stall_pc), 32'd0); adv();

      // Counter saturation and clear
      idle(); clr_cnt = 1'b1;
      eval(); adv();
      clr_cnt = 1'b0; is_load_MEM = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         eval(); adv();
      end
      eval(); chk("cnt2_sat", 32'(d2_stall_cycles), 32'd3);
      chk("cnt4_five", 32'(stall_cycles), 32'd5); adv();
      clr_cnt = 1'b1;
      eval(); adv();
      idle();
      eval(); chk("cnt_clr", 32'(d2_stall_cycles), 32'd0); adv();

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         eval();
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
